// File: rtl/inter_pkg.sv
// Shared types for the read-only slave port: FSM state encoding and wait-state limit.
package inter_pkg;

    localparam int MAX_WAIT_STATES = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        GRANT   = 2'd3
    } ro_slv_state_t;

endpackage

// File: rtl/ro_sram_slave_if.sv
// Per-slave read bus from the interconnect plus the SRAM/ROM macro side.
interface ro_sram_slave_if #(
    parameter int DATA_WIDTH       = 32,
    parameter int SLAVE_ADDR_WIDTH = 10
);
    logic                        slave_data_req_i;
    logic [SLAVE_ADDR_WIDTH-1:0] slave_data_addr_i;
    logic [DATA_WIDTH-1:0]       slave_data_rdata_o;
    logic                        slave_data_gnt_o;
    logic                        inv_i;
    logic                        sram_en_o;
    logic [SLAVE_ADDR_WIDTH-1:0] sram_addr_o;
    logic [DATA_WIDTH-1:0]       sram_dout_i;

    modport slave (
        input  slave_data_req_i, slave_data_addr_i, inv_i, sram_dout_i,
        output slave_data_rdata_o, slave_data_gnt_o, sram_en_o, sram_addr_o
    );

    modport master (
        output slave_data_req_i, slave_data_addr_i, inv_i, sram_dout_i,
        input  slave_data_rdata_o, slave_data_gnt_o, sram_en_o, sram_addr_o
    );
endinterface

// File: rtl/ro_sram_slave.sv
// Read-only slave port: sequences a synchronous SRAM/ROM with wait states and
// keeps the last word in a one-entry hold buffer so retries complete quickly.
module ro_sram_slave
    import inter_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int SLAVE_ADDR_WIDTH = 10,
    parameter int WAIT_STATES      = 0
) (
    input logic              clk,
    input logic              reset,
    ro_sram_slave_if.slave   bus
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    ro_slv_state_t               state, state_nxt;
    logic [SLAVE_ADDR_WIDTH-1:0] addr_q;
    logic [SLAVE_ADDR_WIDTH-1:0] buf_addr;
    logic [DATA_WIDTH-1:0]       rdata_q;
    logic                        buf_valid;
    logic                        stale;
    logic [3:0]                  wait_cnt;
    logic                        addr_match;
    logic                        hit;
    logic                        last_cap;

    assign addr_match = (bus.slave_data_addr_i == buf_addr);
    assign hit        = buf_valid & addr_match;
    assign last_cap   = (state == CAPTURE) && (wait_cnt == WS);

    // Next-state decode; a buffer hit skips the macro entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.slave_data_req_i) state_nxt = hit ? GRANT : READ;
            READ:    state_nxt = CAPTURE;
            CAPTURE: if (wait_cnt == WS) state_nxt = GRANT;
            GRANT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Address is frozen once a miss starts; later input changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                                  addr_q <= '0;
        else if (state == IDLE && bus.slave_data_req_i && !hit)     addr_q <= bus.slave_data_addr_i;
    end

    // Wait-state counter: zero outside CAPTURE, so it is clear on entry and after exit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                             wait_cnt <= '0;
        else if (state == CAPTURE && !last_cap) wait_cnt <= wait_cnt + 4'd1;
        else                                   wait_cnt <= '0;
    end

    // Remember any invalidate that lands while the macro access is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)             stale <= 1'b0;
        else if (state == IDLE) stale <= 1'b0;
        else if (bus.inv_i)    stale <= 1'b1;
    end

    // Hold buffer fill; an invalidate always beats a simultaneous fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            rdata_q   <= '0;
        end else begin
            if (last_cap) begin
                rdata_q  <= bus.sram_dout_i;
                buf_addr <= addr_q;
            end
            if (bus.inv_i)     buf_valid <= 1'b0;
            else if (last_cap) buf_valid <= ~stale;
        end
    end

    assign bus.sram_en_o          = (state == READ);
    assign bus.sram_addr_o        = addr_q;
    assign bus.slave_data_gnt_o   = (state == GRANT) && bus.slave_data_req_i && addr_match;
    assign bus.slave_data_rdata_o = rdata_q;

endmodule
